// File: rtl/calc_pkg.sv
// Shared status codes, FSM state type and 7-segment glyphs for the calculator display.
package calc_pkg;

    localparam logic [1:0] ERRO       = 2'b00;
    localparam logic [1:0] OCUPADO    = 2'b01;
    localparam logic [1:0] PRONTO     = 2'b10;
    localparam logic [1:0] IMPRIMINDO = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StError
    } disp_state_e;

    // Glyphs are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegR     = 7'b0101111;
    localparam logic [6:0] SegO     = 7'b0100011;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegBlank = 7'b1111111;

    function automatic logic [6:0] digit_seg(input logic [3:0] value);
        logic [6:0] s;
        unique case (value)
            4'd0:    s = Seg0;
            4'd1:    s = Seg1;
            4'd2:    s = Seg2;
            4'd3:    s = Seg3;
            4'd4:    s = Seg4;
            4'd5:    s = Seg5;
            4'd6:    s = Seg6;
            4'd7:    s = Seg7;
            4'd8:    s = Seg8;
            4'd9:    s = Seg9;
            default: s = SegDash;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-7-segment decoder with blank and dash overrides.
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SegBlank;
        if (blank) begin
            seg = SegBlank;
        end else if (dash) begin
            seg = SegDash;
        end else begin
            seg = digit_seg(value);
        end
    end

endmodule

// File: rtl/calc_display.sv
// Digit-print receiver: shadow/display double buffer plus multiplexed 7-segment scan.
module calc_display
    import calc_pkg::*;
#(
    parameter int unsigned NDIG     = 8,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      status,
    input  logic [3:0]      data,
    input  logic [3:0]      pos,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            err
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

    disp_state_e          state_q, state_d;
    logic [NDIG-1:0][3:0] shadow_q, shadow_d;
    logic [NDIG-1:0][3:0] disp_q, disp_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [NDIG-1:0]      an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 wr_en;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        wr_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (status == IMPRIMINDO) begin
                    state_d  = StLoad;
                    shadow_d = '0;
                    wr_en    = 1'b1;
                end else if (status == ERRO) begin
                    state_d = StError;
                end
            end
            StLoad: begin
                unique case (status)
                    IMPRIMINDO: wr_en = 1'b1;
                    PRONTO: begin
                        disp_d  = shadow_q;
                        state_d = StIdle;
                    end
                    ERRO:    state_d = StError;
                    default: state_d = StLoad;
                endcase
            end
            StError: state_d = StError;
            default: state_d = StIdle;
        endcase
        // Positions outside 1..NDIG match no slot and are dropped.
        if (wr_en) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (int'(pos) == i + 1) begin
                    shadow_d[i] = data;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Highest nonzero digit; everything above it is blanked.
    logic [IdxW-1:0] hi_idx;
    always_comb begin
        hi_idx = '0;
        for (int i = 1; i < int'(NDIG); i++) begin
            if (disp_q[i] != 4'd0) begin
                hi_idx = IdxW'(i);
            end
        end
    end

    logic [3:0] cur_val;
    logic       cur_blank;
    logic       cur_dash;
    logic [6:0] dec_seg;
    logic [6:0] err_seg;

    assign cur_val   = disp_q[idx_q];
    assign cur_blank = (idx_q > hi_idx);
    assign cur_dash  = (cur_val > 4'd9);

    seg7_decoder u_dec (
        .value (cur_val),
        .blank (cur_blank),
        .dash  (cur_dash),
        .seg   (dec_seg)
    );

    always_comb begin
        err_seg = SegBlank;
        if (idx_q == IdxW'(3)) begin
            err_seg = SegE;
        end else if (idx_q == IdxW'(2) || idx_q == IdxW'(1)) begin
            err_seg = SegR;
        end else if (idx_q == IdxW'(0)) begin
            err_seg = SegO;
        end
    end

    always_comb begin
        an_d  = ~(NDIG'(1) << idx_q);
        seg_d = (state_q == StError) ? err_seg : dec_seg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            disp_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= SegBlank;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign err = (state_q == StError);

endmodule

// File: doc/calc_display.md
# calc_display

Display receiver for the calculator's digit-print stream. Samples `status`/`data`/`pos` from the calculator core, reassembles up to eight BCD digits into a shadow buffer, and commits them atomically to a display buffer when printing ends. Time-multiplexes that buffer onto eight common-anode 7-segment displays, with leading-zero blanking and an "Erro" screen.

## Interface
- `NDIG`, 8: number of display digits; digit 0 is rightmost.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit (≥2).
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `status` in 2: core status; 00 erro, 01 ocupado, 10 pronto, 11 imprimindo.
- `data` in 4: digit value being printed.
- `pos` in 4: print position + 1; valid values 1..8.
- `an` out 8: digit enables, active-low, one-hot-low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `err` out 1: high while the error screen is shown.

## Operation
- Inputs are sampled every cycle; no other handshake. The core holds `status`=11 during a print and presents one new `data`/`pos` pair per cycle.
- FSM states: IDLE, LOAD, ERROR.
- IDLE: `status`=11 -> LOAD; shadow buffer cleared to 0 in the same cycle, and that cycle's `data` written if `pos` is valid. `status`=00 -> ERROR.
- LOAD: `status`=11 and `pos` in 1..8 -> `shadow[pos-1] <= data`. `pos`=0 or `pos`>8 -> ignored. `status`=10 -> copy shadow to display buffer, go to IDLE. `status`=01 -> hold in LOAD. `status`=00 -> ERROR without a commit.
- ERROR: absorbing until reset; `err`=1; all inputs ignored.
- Rendering (non-error):
  - Digit i is blank if i > highest index with a nonzero value; digit 0 is never blanked.
  - Values 10..15 render as '-' (seg 0111111) and count as nonzero.
- Rendering (error): digits 3..0 show E, r, r, o; digits 7..4 are blank.
- Display buffer changes only on commit; the display never shows a partial print.

## Timing
- Reset values: `an`=8'hFF, `seg`=7'h7F, `err`=0, state IDLE, both buffers 0, scan index 0, scan counter 0.
- Scan counter runs 0..SCAN_DIV-1. On wrap, the index advances 0..NDIG-1 and wraps to 0.
- `an` and `seg` are registered. They reflect the current index and the display buffer one cycle after either changes. The first slot after reset begins the cycle after release.
- Commit: buffer updated on the edge that samples `status`=10 in LOAD. It is visible on `seg` one cycle later when its digit is active.
- `err` rises one cycle after `status`=00 is sampled.
- Reset asserted mid-print: everything returns to reset values immediately; the partial print is discarded.
- Simultaneous commit and scan advance: the new slot shows new buffer contents.

## Structure
- Shared package `calc_pkg`:
  - status code constants (ERRO, OCUPADO, PRONTO, IMPRIMINDO);
  - display state enum typedef;
  - segment constants for 0-9, E, r, o, '-', blank.
- Sub-module `seg7_decoder`: combinational 4-bit value plus blank/dash flags -> 7-bit active-low segments; instantiated once on the muxed digit.

## Test plan
- Reset low 5 cycles, then release with SCAN_DIV=4 -> `an`=FF/`seg`=7F during reset. Afterwards, digit 0 shows seg 1000000 ('0') and all other slots show 7F.
- Print with status=11, pos=1..8, data=3,2,1,0,0,0,0,0, then status=10 -> digits 2..0 show 1,2,3 (seg 1111001, 0100100, 0110000); digits 7..3 blank; old contents shown until commit.
- SCAN_DIV=4, idle -> `an` sequence FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles.
- status=00 mid-print -> `err`=1 next cycle; digits 3..0 show E, r, r, o. A following status=11/10 sequence changes nothing until reset.
- Reset asserted after 4 digits loaded -> outputs at reset values at once; after release the display shows a single '0'.
- During a print, pos=0 and pos=9 writes are ignored; data=12 at pos=1 followed by a commit -> digit 0 shows '-' (0111111).
